// File: rtl/ibex_xif_prefetch_ctrl.sv
// ibex_xif_prefetch_ctrl: instruction bus master that tracks in-order outstanding fetches and pushes them into the fetch FIFO
module ibex_xif_prefetch_ctrl #(
  parameter int unsigned NUM_REQS = 2,
  parameter bit          ResetAll = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  output logic                busy_o,
  output logic                fifo_clear_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i
);
  logic [NUM_REQS-1:0] outst_q, outst_d, disc_q, disc_d;
  logic [NUM_REQS-1:0] outst_rev, outst_push, disc_set, free_lsb;
  logic                fifo_ready, new_req, req_held_q, push;
  logic                fetch_addr_en, stored_addr_en;
  logic [31:0]         fetch_addr_q, fetch_addr_d, stored_addr_q, branch_addr;
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_rev
    assign outst_rev[i] = outst_q[NUM_REQS-1-i];
  end
  assign branch_addr    = {addr_i[31:2], 2'b00};
  assign fifo_ready     = ~&(fifo_busy_i | outst_rev);
  assign new_req        = req_i & (fifo_ready | branch_i) & ~outst_q[NUM_REQS-1];
  assign instr_req_o    = new_req | req_held_q;
  assign push           = instr_req_o & instr_gnt_i;
  assign instr_addr_o   = branch_i ? branch_addr : req_held_q ? stored_addr_q : fetch_addr_q;
  assign fetch_addr_en  = push | branch_i;
  assign fetch_addr_d   = push ? instr_addr_o + 32'd4 : branch_addr;
  assign stored_addr_en = branch_i | (instr_req_o & ~instr_gnt_i);
  assign busy_o         = instr_req_o | (|outst_q);
  assign fifo_clear_o   = branch_i;
  assign fifo_valid_o   = instr_rvalid_i & ~disc_q[0] & ~branch_i;
  assign fifo_addr_o    = addr_i;
  assign fifo_rdata_o   = instr_rdata_i;
  assign fifo_err_o     = instr_err_i;
  // grant fills the lowest free slot, branch marks older entries for discard, response retires the oldest
  always_comb begin
    free_lsb   = ~outst_q & {outst_q[NUM_REQS-2:0], 1'b1};
    outst_push = outst_q | (push ? free_lsb : '0);
    disc_set   = disc_q | (branch_i ? outst_q : '0);
    outst_d    = instr_rvalid_i ? outst_push >> 1 : outst_push;
    disc_d     = (instr_rvalid_i ? disc_set >> 1 : disc_set) & outst_d;
  end
  // control state: outstanding/discard tracking and the held-request flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_q    <= '0;
      disc_q     <= '0;
      req_held_q <= 1'b0;
    end else begin
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      req_held_q <= instr_req_o & ~instr_gnt_i;
    end
  end
  if (ResetAll) begin : g_addr_rst
    // fetch and held-request addresses, cleared on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        fetch_addr_q  <= '0;
        stored_addr_q <= '0;
      end else begin
        if (fetch_addr_en) fetch_addr_q <= fetch_addr_d;
        if (stored_addr_en) stored_addr_q <= instr_addr_o;
      end
    end
  end else begin : g_addr_nr
    // fetch and held-request addresses, left unreset to save reset routing
    always_ff @(posedge clk_i) begin
      if (fetch_addr_en) fetch_addr_q <= fetch_addr_d;
      if (stored_addr_en) stored_addr_q <= instr_addr_o;
    end
  end
  a_rvalid_outst: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> outst_q[0]);
  a_push_space: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_valid_o |-> ~&fifo_busy_i);
  a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (instr_req_o & ~instr_gnt_i) |=> (branch_i | (instr_req_o & $stable(instr_addr_o))));
endmodule

// File: tb/tb_ibex_xif_prefetch_ctrl.sv
// tb_ibex_xif_prefetch_ctrl: directed scenario bench for the instruction prefetch controller
module tb_ibex_xif_prefetch_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        busy_o;
  logic        fifo_clear_o;
  logic [1:0]  fifo_busy_i = '0;
  logic        fifo_valid_o;
  logic [31:0] fifo_addr_o;
  logic [31:0] fifo_rdata_o;
  logic        fifo_err_o;
  logic        instr_req_o;
  logic        instr_gnt_i = 1'b0;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_err_i = 1'b0;
  int total = 0;
  int bad = 0;

  ibex_xif_prefetch_ctrl #(.NUM_REQS(2), .ResetAll(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .busy_o(busy_o), .fifo_clear_o(fifo_clear_o), .fifo_busy_i(fifo_busy_i),
    .fifo_valid_o(fifo_valid_o), .fifo_addr_o(fifo_addr_o), .fifo_rdata_o(fifo_rdata_o),
    .fifo_err_o(fifo_err_o), .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
    .instr_addr_o(instr_addr_o), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic test_reset();
    @(negedge clk_i); #1;
    total++; if (instr_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", instr_req_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    total++; if (fifo_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", fifo_valid_o); end
    total++; if (fifo_clear_o !== 1'b0) begin bad++; $display("FAIL rst_clear got=%b exp=0", fifo_clear_o); end
    total++; if (dut.outst_q !== 2'b00) begin bad++; $display("FAIL rst_outst got=%b exp=00", dut.outst_q); end
    @(negedge clk_i); rst_ni = 1'b1;
  endtask

  task automatic test_branch_fetch();
    @(negedge clk_i); req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h80; #1;
    total++; if (fifo_clear_o !== 1'b1) begin bad++; $display("FAIL t1_clear got=%b exp=1", fifo_clear_o); end
    total++; if (instr_addr_o !== 32'h80) begin bad++; $display("FAIL t1_addr got=%h exp=00000080", instr_addr_o); end
    total++; if (instr_req_o !== 1'b1) begin bad++; $display("FAIL t1_req got=%b exp=1", instr_req_o); end
    @(negedge clk_i); branch_i = 1'b0; instr_gnt_i = 1'b1; #1;
    total++; if (instr_addr_o !== 32'h80) begin bad++; $display("FAIL t1_held_addr got=%h exp=00000080", instr_addr_o); end
    total++; if (fifo_clear_o !== 1'b0) begin bad++; $display("FAIL t1_clear_pulse got=%b exp=0", fifo_clear_o); end
    @(negedge clk_i); instr_gnt_i = 1'b0; req_i = 1'b0; #1;
    total++; if (instr_addr_o !== 32'h84) begin bad++; $display("FAIL t1_next_addr got=%h exp=00000084", instr_addr_o); end
    total++; if (instr_req_o !== 1'b0) begin bad++; $display("FAIL t1_req_idle got=%b exp=0", instr_req_o); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL t1_busy_outst got=%b exp=1", busy_o); end
    @(negedge clk_i); instr_rvalid_i = 1'b1; instr_rdata_i = 32'h1111_1111; #1;
    total++; if (fifo_valid_o !== 1'b1) begin bad++; $display("FAIL t1_push got=%b exp=1", fifo_valid_o); end
    @(negedge clk_i); instr_rvalid_i = 1'b0; #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL t1_busy_done got=%b exp=0", busy_o); end
  endtask

  task automatic test_branch_unaligned();
    @(negedge clk_i); req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h102; instr_gnt_i = 1'b1; #1;
    total++; if (instr_addr_o !== 32'h100) begin bad++; $display("FAIL t2_addr got=%h exp=00000100", instr_addr_o); end
    total++; if (fifo_addr_o !== 32'h102) begin bad++; $display("FAIL t2_fifo_addr got=%h exp=00000102", fifo_addr_o); end
    @(negedge clk_i); req_i = 1'b0; branch_i = 1'b0; instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b1; instr_rdata_i = 32'hDEAD_BEEF; #1;
    total++; if (fifo_valid_o !== 1'b1) begin bad++; $display("FAIL t2_push got=%b exp=1", fifo_valid_o); end
    total++; if (fifo_rdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL t2_rdata got=%h exp=deadbeef", fifo_rdata_o); end
    total++; if (fifo_err_o !== 1'b0) begin bad++; $display("FAIL t2_err got=%b exp=0", fifo_err_o); end
    @(negedge clk_i); instr_rvalid_i = 1'b0; #1;
    total++; if (instr_addr_o !== 32'h104) begin bad++; $display("FAIL t2_next_addr got=%h exp=00000104", instr_addr_o); end
  endtask

  task automatic test_grant_withheld();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i); req_i = (c < 2); #1;
      total++; if (instr_req_o !== 1'b1) begin bad++; $display("FAIL t3_req_hold c=%0d got=%b exp=1", c, instr_req_o); end
      total++; if (instr_addr_o !== 32'h104) begin bad++; $display("FAIL t3_addr_hold c=%0d got=%h exp=00000104", c, instr_addr_o); end
    end
    @(negedge clk_i); instr_gnt_i = 1'b1; #1;
    total++; if (instr_req_o !== 1'b1) begin bad++; $display("FAIL t3_req_gnt got=%b exp=1", instr_req_o); end
    @(negedge clk_i); instr_gnt_i = 1'b0; #1;
    total++; if (instr_req_o !== 1'b0) begin bad++; $display("FAIL t3_req_released got=%b exp=0", instr_req_o); end
    total++; if (instr_addr_o !== 32'h108) begin bad++; $display("FAIL t3_next_addr got=%h exp=00000108", instr_addr_o); end
    @(negedge clk_i); instr_rvalid_i = 1'b1; #1;
    total++; if (fifo_valid_o !== 1'b1) begin bad++; $display("FAIL t3_push got=%b exp=1", fifo_valid_o); end
    @(negedge clk_i); instr_rvalid_i = 1'b0;
  endtask

  task automatic test_branch_discard();
    @(negedge clk_i); req_i = 1'b1; instr_gnt_i = 1'b1; #1;
    total++; if (instr_addr_o !== 32'h108) begin bad++; $display("FAIL t4_addr0 got=%h exp=00000108", instr_addr_o); end
    @(negedge clk_i); #1;
    total++; if (instr_addr_o !== 32'h10C) begin bad++; $display("FAIL t4_addr1 got=%h exp=0000010c", instr_addr_o); end
    @(negedge clk_i); instr_gnt_i = 1'b0; branch_i = 1'b1; addr_i = 32'h200; #1;
    total++; if (dut.outst_q !== 2'b11) begin bad++; $display("FAIL t4_full got=%b exp=11", dut.outst_q); end
    total++; if (instr_req_o !== 1'b0) begin bad++; $display("FAIL t4_req_full got=%b exp=0", instr_req_o); end
    total++; if (fifo_clear_o !== 1'b1) begin bad++; $display("FAIL t4_clear got=%b exp=1", fifo_clear_o); end
    @(negedge clk_i); branch_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hAAAA_AAAA; #1;
    total++; if (fifo_valid_o !== 1'b0) begin bad++; $display("FAIL t4_drop0 got=%b exp=0", fifo_valid_o); end
    total++; if (instr_req_o !== 1'b0) begin bad++; $display("FAIL t4_req_still_full got=%b exp=0", instr_req_o); end
    @(negedge clk_i); instr_rdata_i = 32'hBBBB_BBBB; instr_gnt_i = 1'b1; #1;
    total++; if (fifo_valid_o !== 1'b0) begin bad++; $display("FAIL t4_drop1 got=%b exp=0", fifo_valid_o); end
    total++; if (instr_req_o !== 1'b1) begin bad++; $display("FAIL t4_req_resume got=%b exp=1", instr_req_o); end
    total++; if (instr_addr_o !== 32'h200) begin bad++; $display("FAIL t4_target got=%h exp=00000200", instr_addr_o); end
    @(negedge clk_i); instr_gnt_i = 1'b0; req_i = 1'b0; instr_rdata_i = 32'hCCCC_CCCC; #1;
    total++; if (fifo_valid_o !== 1'b1) begin bad++; $display("FAIL t4_push_target got=%b exp=1", fifo_valid_o); end
    @(negedge clk_i); instr_rvalid_i = 1'b0; #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL t4_idle got=%b exp=0", busy_o); end
  endtask

  task automatic test_fifo_backpressure();
    @(negedge clk_i); req_i = 1'b1; instr_gnt_i = 1'b1; #1;
    total++; if (instr_addr_o !== 32'h204) begin bad++; $display("FAIL t5_addr got=%h exp=00000204", instr_addr_o); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i); instr_gnt_i = 1'b0; fifo_busy_i = 2'b01; #1;
      total++; if (instr_req_o !== 1'b0) begin bad++; $display("FAIL t5_stall c=%0d got=%b exp=0", c, instr_req_o); end
    end
    @(negedge clk_i); fifo_busy_i = 2'b00; #1;
    total++; if (instr_req_o !== 1'b1) begin bad++; $display("FAIL t5_resume got=%b exp=1", instr_req_o); end
    total++; if (instr_addr_o !== 32'h208) begin bad++; $display("FAIL t5_resume_addr got=%h exp=00000208", instr_addr_o); end
    @(negedge clk_i); instr_gnt_i = 1'b1; instr_rvalid_i = 1'b1; #1;
    total++; if (fifo_valid_o !== 1'b1) begin bad++; $display("FAIL t5_push0 got=%b exp=1", fifo_valid_o); end
    @(negedge clk_i); instr_gnt_i = 1'b0; req_i = 1'b0; #1;
    total++; if (fifo_valid_o !== 1'b1) begin bad++; $display("FAIL t5_push1 got=%b exp=1", fifo_valid_o); end
    @(negedge clk_i); instr_rvalid_i = 1'b0; #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL t5_idle got=%b exp=0", busy_o); end
  endtask

  task automatic test_err_and_overlap();
    @(negedge clk_i); req_i = 1'b1; instr_gnt_i = 1'b1; #1;
    total++; if (instr_addr_o !== 32'h20C) begin bad++; $display("FAIL t6_addr got=%h exp=0000020c", instr_addr_o); end
    @(negedge clk_i); instr_rvalid_i = 1'b1; instr_err_i = 1'b1; instr_rdata_i = 32'h5; #1;
    total++; if (fifo_err_o !== 1'b1) begin bad++; $display("FAIL t6_err got=%b exp=1", fifo_err_o); end
    total++; if (fifo_valid_o !== 1'b1) begin bad++; $display("FAIL t6_err_push got=%b exp=1", fifo_valid_o); end
    @(negedge clk_i); req_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_err_i = 1'b0; #1;
    total++; if (dut.outst_q !== 2'b01) begin bad++; $display("FAIL t6_outst got=%b exp=01", dut.outst_q); end
    total++; if (instr_addr_o !== 32'h214) begin bad++; $display("FAIL t6_next_addr got=%h exp=00000214", instr_addr_o); end
    @(negedge clk_i); instr_rvalid_i = 1'b1; #1;
    total++; if (fifo_valid_o !== 1'b1 || fifo_err_o !== 1'b0) begin bad++; $display("FAIL t6_drain got=%b%b exp=10", fifo_valid_o, fifo_err_o); end
    @(negedge clk_i); instr_rvalid_i = 1'b0; #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL t6_idle got=%b exp=0", busy_o); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk_i); req_i = 1'b1; instr_gnt_i = 1'b1;
    @(negedge clk_i); req_i = 1'b0; instr_gnt_i = 1'b0; rst_ni = 1'b0; #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL t7_busy got=%b exp=0", busy_o); end
    total++; if (dut.outst_q !== 2'b00) begin bad++; $display("FAIL t7_outst got=%b exp=00", dut.outst_q); end
    @(negedge clk_i); rst_ni = 1'b1; #1;
    total++; if (instr_req_o !== 1'b0) begin bad++; $display("FAIL t7_req got=%b exp=0", instr_req_o); end
  endtask

  initial begin
    test_reset();
    test_branch_fetch();
    test_branch_unaligned();
    test_grant_withheld();
    test_branch_discard();
    test_fifo_backpressure();
    test_err_and_overlap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
